// File: rtl/restoring_div_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential restoring divider.
// The divider core is the slave; the requesting engine and result consumer together form the master side.
interface restoring_div_seq_ctrl_if #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 2
);
  localparam int unsigned Q = N - M + 1;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_dividend;
  logic [M-1:0] in_divisor;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [Q-1:0] out_q;
  logic [N-1:0] out_rem;
  logic         out_dz;
  logic         out_ovf;
  logic         busy;

  modport slave (
    input  in_valid, in_dividend, in_divisor, abort, out_ready,
    output in_ready, out_valid, out_q, out_rem, out_dz, out_ovf, busy
  );

  modport master (
    output in_valid, in_dividend, in_divisor, abort, out_ready,
    input  in_ready, out_valid, out_q, out_rem, out_dz, out_ovf, busy
  );
endinterface

// File: rtl/restoring_div_seq_ctrl.sv
// Sequential restoring divider: one quotient bit per RUN cycle, valid/ready on both sides,
// divide-by-zero and quotient overflow flagged up front instead of iterating.
module restoring_div_seq_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  restoring_div_seq_ctrl_if.slave bus
);
  localparam int unsigned Q  = N - M + 1;
  localparam int unsigned W  = N + 1;
  localparam int unsigned SW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_r;
  logic [M-1:0]   r_d;
  logic [SW-1:0]  r_step;
  logic [Q-1:0]   r_q;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
  logic [Q-1:0]   r_out_q;
  logic [N-1:0]   r_out_rem;
  logic           r_out_dz;
  logic           r_out_ovf;

  logic [W-1:0]   w_dvd_ext;
  logic [W-1:0]   w_dvs_shq;
  logic [W-1:0]   w_trial;
  logic [W-1:0]   w_t;
  logic           w_t_neg;
  logic [Q-1:0]   w_q_next;
  logic [N-1:0]   w_rem_next;

  // D<<Q spans exactly M+Q = N+1 bits, so the overflow compare never loses divisor bits.
  assign w_dvd_ext = {1'b0, bus.in_dividend};
  assign w_dvs_shq = {{(W-M){1'b0}}, bus.in_divisor} << Q;
  assign w_trial   = {{(W-M){1'b0}}, r_d} << r_step;
  assign w_t       = r_r - w_trial;
  assign w_t_neg   = w_t[W-1];

  always_comb begin
    w_q_next = r_q;
    for (int unsigned i = 0; i < Q; i++) begin
      if (r_step == SW'(i)) w_q_next[i] = ~w_t_neg;
    end
    w_rem_next = w_t_neg ? r_r[N-1:0] : w_t[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_r         <= '0;
      r_d         <= '0;
      r_step      <= '0;
      r_q         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_q     <= '0;
      r_out_rem   <= '0;
      r_out_dz    <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_r        <= w_dvd_ext;
            r_d        <= bus.in_divisor;
            r_step     <= SW'(Q - 1);
            r_q        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.in_divisor == '0) begin
              r_out_dz    <= 1'b1;
              r_out_ovf   <= 1'b0;
              r_out_q     <= '1;
              r_out_rem   <= bus.in_dividend;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_dvd_ext >= w_dvs_shq) begin
              r_out_dz    <= 1'b0;
              r_out_ovf   <= 1'b1;
              r_out_q     <= '1;
              r_out_rem   <= bus.in_dividend;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_out_dz  <= 1'b0;
              r_out_ovf <= 1'b0;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_q <= w_q_next;
            if (!w_t_neg) r_r <= w_t;
            if (r_step == '0) begin
              r_out_q     <= w_q_next;
              r_out_rem   <= w_rem_next;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_step <= r_step - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready || bus.abort) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.out_q     = r_out_q;
  assign bus.out_rem   = r_out_rem;
  assign bus.out_dz    = r_out_dz;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_restoring_div_seq_ctrl.sv
// Directed and swept checks of the sequential restoring divider against hand-computed
// results and a plain integer division model.
module tb_restoring_div_seq_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned M = 2;
  localparam int unsigned Q = N - M + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  restoring_div_seq_ctrl_if #(.N(N), .M(M)) bus ();

  restoring_div_seq_ctrl #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_busy"},      32'(bus.busy),      0);
    chk({tag, "_q"},         32'(bus.out_q),     0);
    chk({tag, "_rem"},       32'(bus.out_rem),   0);
    chk({tag, "_dz"},        32'(bus.out_dz),    0);
    chk({tag, "_ovf"},       32'(bus.out_ovf),   0);
  endtask

  // Offers a/b, optionally pokes in_valid with junk operands during RUN, waits (bounded) for
  // out_valid, checks result and latency, holds out_ready low for 'stall' cycles, then consumes.
  task automatic run_div(input string tag, input int a, input int b, input int stall,
                         input int eq, input int er, input int edz, input int eovf,
                         input int elat, input bit poke);
    int lat;
    bus.in_dividend = 4'(a);
    bus.in_divisor  = 2'(b);
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    if (poke) begin
      bus.in_valid    = 1'b1;
      bus.in_dividend = 4'(a ^ 15);
      bus.in_divisor  = 2'(b ^ 3);
    end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (poke) chk({tag, "_in_ready_run"}, 32'(bus.in_ready), 0);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat),              32'(elat));
    chk({tag, "_valid"},   32'(bus.out_valid),    1);
    chk({tag, "_q"},       32'(bus.out_q),        32'(eq));
    chk({tag, "_rem"},     32'(bus.out_rem),      32'(er));
    chk({tag, "_dz"},      32'(bus.out_dz),       32'(edz));
    chk({tag, "_ovf"},     32'(bus.out_ovf),      32'(eovf));
    chk({tag, "_busy"},    32'(bus.busy),         1);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
      chk({tag, "_hold_q"},     32'(bus.out_q),     32'(eq));
      chk({tag, "_hold_rem"},   32'(bus.out_rem),   32'(er));
      chk({tag, "_hold_rdy"},   32'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_idle_rdy"},   32'(bus.in_ready),  1);
    chk({tag, "_idle_busy"},  32'(bus.busy),      0);
  endtask

  initial begin
    int cnt;
    int eq, er, edz, eovf;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.abort       = 1'b0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    run_div("d13_3", 13, 3, 0, 4, 1, 0, 0, 3, 1'b0);
    run_div("d7_2",   7, 2, 0, 3, 1, 0, 0, 3, 1'b0);
    run_div("d2_3",   2, 3, 0, 0, 2, 0, 0, 3, 1'b0);
    run_div("d15_2", 15, 2, 0, 7, 1, 0, 0, 3, 1'b1);
    run_div("ovf8_1", 8, 1, 0, 7, 8, 0, 1, 0, 1'b0);
    run_div("d7_1",   7, 1, 0, 7, 0, 0, 0, 3, 1'b0);
    run_div("dz9_0",  9, 0, 0, 7, 9, 1, 0, 0, 1'b0);
    run_div("bp13_3",13, 3, 4, 4, 1, 0, 0, 3, 1'b0);

    // abort during the second RUN cycle
    bus.in_dividend = 4'd13;
    bus.in_divisor  = 2'd3;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_rdy",  32'(bus.in_ready),  1);
    chk("abort_busy", 32'(bus.busy),      0);
    chk("abort_val",  32'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_noval", 32'(bus.out_valid), 0);
    end
    run_div("d10_3", 10, 3, 0, 3, 1, 0, 0, 3, 1'b0);

    // abort while the result waits in DONE discards it
    bus.in_dividend = 4'd7;
    bus.in_divisor  = 2'd2;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("dabort_reached", 32'(bus.out_valid), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("dabort_val", 32'(bus.out_valid), 0);
    chk("dabort_rdy", 32'(bus.in_ready),  1);

    // reset in the middle of RUN
    bus.in_dividend = 4'd13;
    bus.in_divisor  = 2'd3;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst_run");
    tick();
    chk("rst_run_noval", 32'(bus.out_valid), 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 0) begin
          edz = 1; eovf = 0; eq = 7; er = a;
        end else if (a >= (b << Q)) begin
          edz = 0; eovf = 1; eq = 7; er = a;
        end else begin
          edz = 0; eovf = 0; eq = a / b; er = a % b;
        end
        run_div($sformatf("sw%0d_%0d", a, b), a, b, int'($urandom_range(0, 3)),
                eq, er, edz, eovf, (edz == 1 || eovf == 1) ? 0 : 3, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
